// File: rtl/inst_mem_loader_pkg.sv
// Shared definitions for the instruction memory loader.
//   ADDR_W / INST_W / DEPTH : instruction memory geometry
//   LEN_HI_RSVD / DATA_HI_RSVD : bits that must be zero in the frame bytes
//   state_t : loader FSM states
package inst_mem_loader_pkg;

    localparam int ADDR_W = 12;
    localparam int INST_W = 14;
    localparam int DEPTH  = 4096;

    localparam logic [7:0] LEN_HI_RSVD  = 8'hF0;
    localparam logic [7:0] DATA_HI_RSVD = 8'hC0;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA_LO,
        DATA_HI,
        CHECK,
        DONE,
        ERR
    } state_t;

endpackage

// File: rtl/inst_mem_loader_checksum.sv
// loader_checksum: 8-bit mod-256 running sum of frame bytes.
//   clk, rst : clock and synchronous active-high reset
//   clr      : zero the sum (new load)
//   add_en   : add data to the sum this cycle
//   data     : byte to accumulate
//   sum      : current accumulated value
module loader_checksum (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       add_en,
    input  logic [7:0] data,
    output logic [7:0] sum
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sum <= 8'h00;
        end else if (add_en) begin
            sum <= sum + data;
        end
    end

endmodule

// File: rtl/inst_mem_loader.sv
// inst_mem_loader: boot-time writer for the CPU instruction memory.
// Parses a framed byte stream (length, payload word pairs, checksum),
// writes 14-bit words to consecutive addresses from 0 and releases the
// CPU only after a clean load.
//   clk, rst      : clock, synchronous active-high reset
//   start         : begin a load (honoured in IDLE, DONE, ERR)
//   in_data/in_valid/in_ready : byte stream handshake
//   wr_en/wr_addr/wr_data     : registered instruction memory write port
//   cpu_hold      : hold CPU in reset (low only in DONE)
//   done / err    : status of the last load
//   words_loaded  : words written in the current or last load
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | after reset, waiting for start
// LEN_LO  | expecting length[7:0]
// LEN_HI  | expecting length[11:8], upper nibble reserved
// DATA_LO | expecting word[7:0]
// DATA_HI | expecting word[13:8], bits 7:6 reserved
// CHECK   | expecting checksum byte
// DONE    | load good, CPU released
// ERR     | load failed, CPU held
module inst_mem_loader
    import inst_mem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [INST_W-1:0] wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] len_q;
    logic [7:0]        data_lo_q;
    logic [7:0]        sum;
    logic [ADDR_W:0]   words_inc;
    logic              accept;
    logic              start_ok;
    logic              add_en;
    logic              hi_rsvd_bad;
    logic              len_rsvd_bad;
    logic              len_zero;

    assign accept       = in_valid && in_ready;
    assign start_ok     = start && (state == IDLE || state == DONE || state == ERR);
    assign add_en       = accept && (state == LEN_LO || state == LEN_HI ||
                                     state == DATA_LO || state == DATA_HI);
    assign hi_rsvd_bad  = (in_data & DATA_HI_RSVD) != 8'h00;
    assign len_rsvd_bad = (in_data & LEN_HI_RSVD) != 8'h00;
    // length is only fully known one cycle after LEN_HI, so test it from the live byte
    assign len_zero     = {in_data[3:0], len_q[7:0]} == '0;
    assign words_inc    = words_loaded + 1'b1;

    assign cpu_hold = (state != DONE);
    assign done     = (state == DONE);
    assign err      = (state == ERR);

    loader_checksum u_checksum (
        .clk    (clk),
        .rst    (rst),
        .clr    (start_ok),
        .add_en (add_en),
        .data   (in_data),
        .sum    (sum)
    );

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            IDLE, DONE, ERR: begin
                if (start) state_nxt = LEN_LO;
            end
            LEN_LO: begin
                in_ready = 1'b1;
                if (accept) state_nxt = LEN_HI;
            end
            LEN_HI: begin
                in_ready = 1'b1;
                if (accept) begin
                    if (len_rsvd_bad)  state_nxt = ERR;
                    else if (len_zero) state_nxt = CHECK;
                    else               state_nxt = DATA_LO;
                end
            end
            DATA_LO: begin
                in_ready = 1'b1;
                if (accept) state_nxt = DATA_HI;
            end
            DATA_HI: begin
                in_ready = 1'b1;
                if (accept) begin
                    if (hi_rsvd_bad)                     state_nxt = ERR;
                    else if (words_inc == {1'b0, len_q}) state_nxt = CHECK;
                    else                                 state_nxt = DATA_LO;
                end
            end
            CHECK: begin
                in_ready = 1'b1;
                if (accept) state_nxt = (in_data == sum) ? DONE : ERR;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            len_q        <= '0;
            data_lo_q    <= 8'h00;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            words_loaded <= '0;
        end else begin
            state <= state_nxt;
            wr_en <= 1'b0;
            if (start_ok) words_loaded <= '0;
            if (accept) begin
                case (state)
                    LEN_LO:  len_q[7:0]          <= in_data;
                    LEN_HI:  len_q[ADDR_W-1:8]   <= in_data[3:0];
                    DATA_LO: data_lo_q           <= in_data;
                    DATA_HI: begin
                        if (!hi_rsvd_bad) begin
                            wr_en        <= 1'b1;
                            wr_addr      <= words_loaded[ADDR_W-1:0];
                            wr_data      <= {in_data[5:0], data_lo_q};
                            words_loaded <= words_inc;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
- Boot-time writer for the CPU instruction memory; the datapath only ever reads that memory.
- Accepts a framed byte stream over a valid/ready handshake and assembles 14-bit instruction words.
- Writes the words to consecutive 12-bit addresses starting at 0, then verifies a checksum.
- Holds the CPU (cpu_hold) until a load completes cleanly.

Parameters:
- ADDR_W, 12, instruction address width; matches PC width.
- INST_W, 14, instruction word width.
- DEPTH, 4096, number of instruction memory words; maximum legal load length.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset. Sampled on the rising edge of clk.
- start  input  1  one-cycle pulse that begins a load. Honoured only in IDLE, DONE or ERR.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts a byte. A transfer occurs when in_valid && in_ready.
- wr_en  output  1  instruction memory write strobe.
- wr_addr  output  ADDR_W  instruction memory write address.
- wr_data  output  INST_W  instruction word to write.
- cpu_hold  output  1  keep CPU PC in reset while high.
- done  output  1  last load completed with checksum match.
- err  output  1  last load failed.
- words_loaded  output  ADDR_W+1  number of words written in the current or last load.

Behaviour:
- Frame format, in order:
  - LEN_LO: length[7:0].
  - LEN_HI: bits [3:0] = length[11:8]; bits [7:4] must be 0.
  - Payload: length pairs of bytes. First byte = word[7:0]. Second byte: bits [5:0] = word[13:8]; bits [7:6] must be 0.
  - Checksum: 8-bit sum, mod 256, of all preceding frame bytes.
- States and transitions:
  - IDLE -> LEN_LO on start.
  - LEN_LO -> LEN_HI on byte accept.
  - LEN_HI -> DATA_LO if length > 0; -> CHECK if length == 0; -> ERR if any reserved bit is set.
  - DATA_LO -> DATA_HI on byte accept.
  - DATA_HI -> DATA_LO if more words remain; -> CHECK after the last word; -> ERR if reserved bits are set.
  - CHECK -> DONE if the checksum byte matches; -> ERR otherwise.
  - DONE and ERR -> LEN_LO on start.
- Length range: length ≤ DEPTH is guaranteed by the 12-bit field, but a value of 0 words is legal.
- in_ready: 1 in LEN_LO, LEN_HI, DATA_LO, DATA_HI, CHECK; 0 in IDLE, DONE, ERR. No backpressure otherwise; the loader accepts one byte per cycle.
- Write timing:
  - Writes use registered outputs. wr_en pulses for exactly one cycle, the cycle after the DATA_HI byte is accepted.
  - wr_addr = running word index, starting at 0 and incrementing after each write.
  - wr_data = {hi[5:0], lo}.
  - A rejected DATA_HI byte (reserved bits set) produces no write.
- words_loaded increments together with each wr_en pulse and clears on start.
- Checksum accumulator:
  - Clears on start.
  - Adds every accepted byte in LEN_LO, LEN_HI, DATA_LO, DATA_HI; wraps mod 256.
- Status outputs:
  - cpu_hold = 1 in every state except DONE.
  - done = 1 only in DONE; err = 1 only in ERR. Both clear on start.
- start outside IDLE/DONE/ERR is ignored; a load in progress is not restarted.
- Reset values: state IDLE; cpu_hold 1; in_ready 0; wr_en 0; wr_addr 0; wr_data 0; done 0; err 0; words_loaded 0; checksum 0.
- Reset mid-load: immediate return to IDLE with all reset values. Words already written are left in memory, but the CPU remains held.
- in_valid while in_ready = 0: the byte is ignored and no state changes.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, LEN_LO, LEN_HI, DATA_LO, DATA_HI, CHECK, DONE, ERR);
  - constants ADDR_W, INST_W, DEPTH;
  - reserved-bit masks LEN_HI_RSVD = 8'hF0 and DATA_HI_RSVD = 8'hC0.
- One natural sub-module, loader_checksum: an 8-bit mod-256 accumulator with clear and add-enable inputs.

Test Plan:
- Reset, start, then bytes 02 00 34 12 CD 2B 40 -> writes 0x1234 @0 and 0x2BCD @1, one cycle after bytes 4 and 6; then done = 1, cpu_hold = 0, words_loaded = 2.
- Same frame with checksum byte 41 -> both writes occur, then err = 1, done = 0, cpu_hold = 1.
- start, bytes 00 00 00 -> no wr_en, done = 1, words_loaded = 0.
- start, bytes 01 00 34 52 (reserved bit 6 set) -> no write, err = 1, and in_ready = 0 from the next cycle.
- rst asserted after 3 payload bytes -> next cycle all outputs at reset values, state IDLE. A following full good frame then loads normally.
- in_valid toggled every other cycle on the good frame -> identical write sequence; no byte dropped or duplicated.
